// File: rtl/OoO_pkg.sv
// Shared types for the core's AXI read-side plumbing.
// Contents: bus widths, AXI read request/response payloads, the read-arbiter
// state encoding and the read-owner encoding.
package OoO_pkg;

    localparam int unsigned AXI_ADDR_W  = 32;
    localparam int unsigned AXI_DATA_W  = 64;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;

    // Master-to-slave half of an AXI read port (AR channel plus R-channel ready).
    typedef struct packed {
        logic                   arvalid;
        logic [AXI_ADDR_W-1:0]  araddr;
        logic [AXI_LEN_W-1:0]   arlen;
        logic [AXI_SIZE_W-1:0]  arsize;
        logic [AXI_BURST_W-1:0] arburst;
        logic                   rready;
    } axi_r_m2s_t;

    // Slave-to-master half of an AXI read port (AR ready plus R channel).
    typedef struct packed {
        logic                   arready;
        logic                   rvalid;
        logic [AXI_DATA_W-1:0]  rdata;
        logic [AXI_RESP_W-1:0]  rresp;
        logic                   rlast;
    } axi_r_s2m_t;

    // AR payload captured at grant and replayed downstream.
    typedef struct packed {
        logic [AXI_ADDR_W-1:0]  araddr;
        logic [AXI_LEN_W-1:0]   arlen;
        logic [AXI_SIZE_W-1:0]  arsize;
        logic [AXI_BURST_W-1:0] arburst;
    } axi_ar_payload_t;

    typedef enum logic [1:0] {
        RD_ARB_IDLE = 2'd0,
        RD_ARB_AR   = 2'd1,
        RD_ARB_RD   = 2'd2
    } rd_arb_state_e;

    typedef enum logic {
        RD_OWNER_IFU = 1'b0,
        RD_OWNER_LSU = 1'b1
    } rd_owner_e;

endpackage

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: IFU refill and LSU share one memory read port.
// Round-robin grant, ownership held for the whole burst, AR latched at grant.
// A frontend flush drains an in-flight IFU burst while hiding its beats.
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   flush_frontend      discard any outstanding IFU read
//   ifu_r_m2s/ifu_r_s2m IFU read request / response
//   lsu_r_m2s/lsu_r_s2m LSU read request / response
//   mem_r_m2s/mem_r_s2m memory-side read request / response
//   arb_busy            state is not IDLE
// AR ready and the R channel are combinational pass-throughs by design.
module axi_rd_arbiter
    import OoO_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush_frontend,
    input  axi_r_m2s_t ifu_r_m2s,
    output axi_r_s2m_t ifu_r_s2m,
    input  axi_r_m2s_t lsu_r_m2s,
    output axi_r_s2m_t lsu_r_s2m,
    output axi_r_m2s_t mem_r_m2s,
    input  axi_r_s2m_t mem_r_s2m,
    output logic       arb_busy
);

    rd_arb_state_e   state_q, state_d;
    rd_owner_e       owner_q, owner_d;
    rd_owner_e       last_owner_q, last_owner_d;
    logic            drop_q, drop_d;
    axi_ar_payload_t ar_q, ar_d;

    logic      ifu_cand;
    logic      lsu_cand;
    rd_owner_e pick;
    logic      flush_ifu;
    logic      drop_now;
    logic      mem_rready;

    // Round-robin pick: on a tie the master that did not own the last burst wins.
    function automatic rd_owner_e rr_pick(input rd_owner_e last, input logic ifu_c,
                                          input logic lsu_c);
        if (ifu_c && lsu_c) begin
            return (last == RD_OWNER_IFU) ? RD_OWNER_LSU : RD_OWNER_IFU;
        end
        return ifu_c ? RD_OWNER_IFU : RD_OWNER_LSU;
    endfunction

    // State and bookkeeping registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= RD_ARB_IDLE;
            owner_q      <= RD_OWNER_IFU;
            last_owner_q <= RD_OWNER_LSU;
            drop_q       <= 1'b0;
            ar_q         <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            drop_q       <= drop_d;
            ar_q         <= ar_d;
        end
    end

    // Next state, grant and channel muxing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        drop_d       = drop_q;
        ar_d         = ar_q;
        ifu_r_s2m    = '0;
        lsu_r_s2m    = '0;
        mem_r_m2s    = '0;
        mem_rready   = 1'b0;

        // Grants are gated by reset so arready reads 0 while reset is held.
        ifu_cand  = ifu_r_m2s.arvalid & ~flush_frontend & reset;
        lsu_cand  = lsu_r_m2s.arvalid & reset;
        pick      = rr_pick(last_owner_q, ifu_cand, lsu_cand);
        flush_ifu = flush_frontend & (owner_q == RD_OWNER_IFU);
        // A flush landing on a beat already hides that beat, including rlast.
        drop_now  = drop_q | flush_ifu;

        mem_r_m2s.araddr  = ar_q.araddr;
        mem_r_m2s.arlen   = ar_q.arlen;
        mem_r_m2s.arsize  = ar_q.arsize;
        mem_r_m2s.arburst = ar_q.arburst;

        case (state_q)
            RD_ARB_IDLE: begin
                if (ifu_cand || lsu_cand) begin
                    owner_d = pick;
                    state_d = RD_ARB_AR;
                    if (pick == RD_OWNER_IFU) begin
                        ifu_r_s2m.arready = 1'b1;
                        ar_d = '{araddr: ifu_r_m2s.araddr, arlen: ifu_r_m2s.arlen,
                                 arsize: ifu_r_m2s.arsize, arburst: ifu_r_m2s.arburst};
                    end else begin
                        lsu_r_s2m.arready = 1'b1;
                        ar_d = '{araddr: lsu_r_m2s.araddr, arlen: lsu_r_m2s.arlen,
                                 arsize: lsu_r_m2s.arsize, arburst: lsu_r_m2s.arburst};
                    end
                end
            end
            RD_ARB_AR: begin
                // The latched AR is always issued, even once dropped.
                mem_r_m2s.arvalid = 1'b1;
                if (flush_ifu) begin
                    drop_d = 1'b1;
                end
                if (mem_r_s2m.arready) begin
                    state_d = RD_ARB_RD;
                end
            end
            RD_ARB_RD: begin
                if (drop_now) begin
                    mem_rready = 1'b1;
                end else if (owner_q == RD_OWNER_IFU) begin
                    mem_rready          = ifu_r_m2s.rready;
                    ifu_r_s2m.rvalid    = mem_r_s2m.rvalid;
                    ifu_r_s2m.rdata     = mem_r_s2m.rdata;
                    ifu_r_s2m.rresp     = mem_r_s2m.rresp;
                    ifu_r_s2m.rlast     = mem_r_s2m.rlast;
                end else begin
                    mem_rready          = lsu_r_m2s.rready;
                    lsu_r_s2m.rvalid    = mem_r_s2m.rvalid;
                    lsu_r_s2m.rdata     = mem_r_s2m.rdata;
                    lsu_r_s2m.rresp     = mem_r_s2m.rresp;
                    lsu_r_s2m.rlast     = mem_r_s2m.rlast;
                end
                if (flush_ifu) begin
                    drop_d = 1'b1;
                end
                if (mem_r_s2m.rvalid && mem_rready && mem_r_s2m.rlast) begin
                    last_owner_d = owner_q;
                    drop_d       = 1'b0;
                    state_d      = RD_ARB_IDLE;
                end
            end
            default: begin
                state_d = RD_ARB_IDLE;
            end
        endcase

        mem_r_m2s.rready = mem_rready;
    end

    assign arb_busy = (state_q != RD_ARB_IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a table of IDLE-arbitration vectors
// followed by hand-written multi-cycle sequences (bursts, flush, reset).
module tb_axi_rd_arbiter;
    import OoO_pkg::*;

    logic       clock;
    logic       reset;
    logic       flush_frontend;
    axi_r_m2s_t ifu_m2s, lsu_m2s, mem_m2s;
    axi_r_s2m_t ifu_s2m, lsu_s2m, mem_s2m;
    logic       arb_busy;

    int n_checks = 0;
    int n_fail   = 0;

    axi_rd_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .flush_frontend (flush_frontend),
        .ifu_r_m2s      (ifu_m2s),
        .ifu_r_s2m      (ifu_s2m),
        .lsu_r_m2s      (lsu_m2s),
        .lsu_r_s2m      (lsu_s2m),
        .mem_r_m2s      (mem_m2s),
        .mem_r_s2m      (mem_s2m),
        .arb_busy       (arb_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic ifu_v;
        logic lsu_v;
        logic flush;
        logic exp_ifu;
        logic exp_lsu;
    } vec_t;

    vec_t vecs[10];

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_w(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_m2s        = '0;
        lsu_m2s        = '0;
        mem_s2m        = '0;
        flush_frontend = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_b({tag, "_busy"},        arb_busy,        1'b0);
        check_b({tag, "_ifu_arready"}, ifu_s2m.arready, 1'b0);
        check_b({tag, "_lsu_arready"}, lsu_s2m.arready, 1'b0);
        check_b({tag, "_ifu_rvalid"},  ifu_s2m.rvalid,  1'b0);
        check_b({tag, "_lsu_rvalid"},  lsu_s2m.rvalid,  1'b0);
        check_b({tag, "_mem_arvalid"}, mem_m2s.arvalid, 1'b0);
        check_b({tag, "_mem_rready"},  mem_m2s.rready,  1'b0);
    endtask

    // From AR state: handshake AR, then return `beats` beats with both rready=1.
    task automatic do_burst(input bit own_ifu, input int beats, input bit fwd);
        axi_r_s2m_t own, oth;
        int got;
        got = 0;
        check_b("burst_mem_arvalid", mem_m2s.arvalid, 1'b1);
        mem_s2m.arready = 1'b1;
        tick();
        mem_s2m.arready = 1'b0;
        for (int i = 0; i < beats; i++) begin
            mem_s2m.rvalid = 1'b1;
            mem_s2m.rdata  = 64'hD000_0000 + 64'(i);
            mem_s2m.rresp  = 2'(i);
            mem_s2m.rlast  = (i == beats - 1);
            ifu_m2s.rready = 1'b1;
            lsu_m2s.rready = 1'b1;
            #1;
            own = own_ifu ? ifu_s2m : lsu_s2m;
            oth = own_ifu ? lsu_s2m : ifu_s2m;
            check_b("beat_owner_rvalid", own.rvalid, fwd);
            check_b("beat_other_rvalid", oth.rvalid, 1'b0);
            check_b("beat_mem_rready", mem_m2s.rready, 1'b1);
            if (fwd) begin
                check_w("beat_rdata", own.rdata, 64'hD000_0000 + 64'(i));
                check_w("beat_rresp", 64'(own.rresp), 64'(i % 4));
                check_b("beat_rlast", own.rlast, (i == beats - 1));
            end
            if (own.rvalid) got++;
            tick();
        end
        mem_s2m.rvalid = 1'b0;
        mem_s2m.rlast  = 1'b0;
        ifu_m2s.rready = 1'b0;
        lsu_m2s.rready = 1'b0;
        #1;
        check_w("burst_beats_seen", 64'(got), fwd ? 64'(beats) : 64'd0);
        check_b("burst_busy_after", arb_busy, 1'b0);
    endtask

    // One IDLE-cycle request; returns with the arbiter in AR (if granted).
    task automatic request(input logic iv, input logic lv, input logic fl,
                           input logic [31:0] ia, input logic [31:0] la, input logic [7:0] len);
        ifu_m2s.arvalid = iv;
        ifu_m2s.araddr  = ia;
        ifu_m2s.arlen   = len;
        ifu_m2s.arsize  = 3'd3;
        ifu_m2s.arburst = 2'd1;
        lsu_m2s.arvalid = lv;
        lsu_m2s.araddr  = la;
        lsu_m2s.arlen   = len;
        lsu_m2s.arsize  = 3'd2;
        lsu_m2s.arburst = 2'd1;
        flush_frontend  = fl;
    endtask

    initial begin
        logic [31:0] ia, la, ea;
        int          got;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        reset = 1'b0;
        idle_inputs();
        #1;
        check_reset_outputs("reset");
        #12;
        reset = 1'b1;
        tick();

        // Table: arbitration from IDLE, each grant completes a single-beat burst.
        for (int v = 0; v < 10; v++) begin
            ia = 32'h8000_0000 + 32'(v * 64);
            la = 32'h1000_0000 + 32'(v * 64);
            request(vecs[v].ifu_v, vecs[v].lsu_v, vecs[v].flush, ia, la, 8'd0);
            #1;
            check_b("vec_ifu_arready", ifu_s2m.arready, vecs[v].exp_ifu);
            check_b("vec_lsu_arready", lsu_s2m.arready, vecs[v].exp_lsu);
            check_b("vec_grant_mem_arvalid", mem_m2s.arvalid, 1'b0);
            tick();
            idle_inputs();
            #1;
            if (vecs[v].exp_ifu || vecs[v].exp_lsu) begin
                ea = vecs[v].exp_ifu ? ia : la;
                check_b("vec_busy", arb_busy, 1'b1);
                check_w("vec_araddr", 64'(mem_m2s.araddr), 64'(ea));
                check_w("vec_arsize", 64'(mem_m2s.arsize), vecs[v].exp_ifu ? 64'd3 : 64'd2);
                do_burst(vecs[v].exp_ifu, 1, 1'b1);
            end else begin
                check_b("vec_no_grant_busy", arb_busy, 1'b0);
            end
        end

        // Lone IFU, arlen=3: arready now, arvalid next cycle, 4 forwarded beats.
        request(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'd3);
        #1;
        check_b("lone_arready_c0", ifu_s2m.arready, 1'b1);
        check_b("lone_mem_arvalid_c0", mem_m2s.arvalid, 1'b0);
        tick();
        idle_inputs();
        #1;
        check_b("lone_mem_arvalid_c1", mem_m2s.arvalid, 1'b1);
        check_w("lone_araddr", 64'(mem_m2s.araddr), 64'h8000_0000);
        check_w("lone_arlen", 64'(mem_m2s.arlen), 64'd3);
        do_burst(1'b1, 4, 1'b1);

        // IFU arlen=7, flush after beat 2, LSU waiting behind it.
        request(1'b1, 1'b0, 1'b0, 32'h8000_0200, 32'h0, 8'd7);
        tick();
        ifu_m2s.arvalid = 1'b0;
        request(1'b0, 1'b1, 1'b0, 32'h0, 32'h1000_0800, 8'd0);
        mem_s2m.arready = 1'b1;
        tick();
        mem_s2m.arready = 1'b0;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            mem_s2m.rvalid = 1'b1;
            mem_s2m.rdata  = 64'hA000 + 64'(i);
            mem_s2m.rlast  = (i == 7);
            flush_frontend = (i == 2);
            ifu_m2s.rready = (i < 2);
            #1;
            if (ifu_s2m.rvalid) got++;
            check_b("flush_lsu_arready", lsu_s2m.arready, 1'b0);
            check_b("flush_lsu_rvalid", lsu_s2m.rvalid, 1'b0);
            if (i >= 2) begin
                check_b("flush_ifu_rvalid", ifu_s2m.rvalid, 1'b0);
                check_b("flush_mem_rready", mem_m2s.rready, 1'b1);
            end
            tick();
        end
        mem_s2m.rvalid = 1'b0;
        mem_s2m.rlast  = 1'b0;
        flush_frontend = 1'b0;
        #1;
        check_w("flush_beats_fwd", 64'(got), 64'd2);
        check_b("flush_idle_busy", arb_busy, 1'b0);
        check_b("flush_lsu_granted", lsu_s2m.arready, 1'b1);
        tick();
        idle_inputs();
        #1;
        check_w("flush_lsu_araddr", 64'(mem_m2s.araddr), 64'h1000_0800);
        do_burst(1'b0, 1, 1'b1);

        // Flush in AR with memory arready low 5 cycles; AR held, beats dropped.
        request(1'b1, 1'b0, 1'b0, 32'h8000_1000, 32'h0, 8'd1);
        tick();
        ifu_m2s.arvalid = 1'b0;
        ifu_m2s.araddr  = 32'hDEAD_BEEF;
        flush_frontend  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_b("arflush_arvalid", mem_m2s.arvalid, 1'b1);
            check_w("arflush_araddr", 64'(mem_m2s.araddr), 64'h8000_1000);
            tick();
            flush_frontend = 1'b0;
        end
        do_burst(1'b1, 2, 1'b0);

        // Fresh reset; both request: IFU first, LSU held off until IFU's rlast.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        idle_inputs();
        tick();
        request(1'b1, 1'b1, 1'b0, 32'h8000_2000, 32'h1000_2000, 8'd1);
        #1;
        check_b("both_ifu_arready", ifu_s2m.arready, 1'b1);
        check_b("both_lsu_arready_c0", lsu_s2m.arready, 1'b0);
        tick();
        ifu_m2s.arvalid = 1'b0;
        mem_s2m.arready = 1'b1;
        #1;
        check_b("both_lsu_arready_ar", lsu_s2m.arready, 1'b0);
        tick();
        mem_s2m.arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_s2m.rvalid = 1'b1;
            mem_s2m.rlast  = (i == 1);
            ifu_m2s.rready = 1'b1;
            #1;
            check_b("both_lsu_arready_rd", lsu_s2m.arready, 1'b0);
            check_b("both_ifu_rvalid", ifu_s2m.rvalid, 1'b1);
            tick();
        end
        mem_s2m.rvalid = 1'b0;
        mem_s2m.rlast  = 1'b0;
        ifu_m2s.rready = 1'b0;
        #1;
        check_b("both_lsu_granted", lsu_s2m.arready, 1'b1);
        tick();
        idle_inputs();
        #1;
        check_w("both_lsu_araddr", 64'(mem_m2s.araddr), 64'h1000_2000);
        do_burst(1'b0, 1, 1'b1);

        // Flush coincident with IFU rlast: burst ends, beat hidden, drop cleared.
        request(1'b1, 1'b0, 1'b0, 32'h8000_3000, 32'h0, 8'd1);
        tick();
        idle_inputs();
        mem_s2m.arready = 1'b1;
        tick();
        mem_s2m.arready = 1'b0;
        mem_s2m.rvalid  = 1'b1;
        ifu_m2s.rready  = 1'b1;
        #1;
        check_b("lastflush_beat1_fwd", ifu_s2m.rvalid, 1'b1);
        tick();
        mem_s2m.rlast  = 1'b1;
        flush_frontend = 1'b1;
        #1;
        check_b("lastflush_ifu_rvalid", ifu_s2m.rvalid, 1'b0);
        check_b("lastflush_mem_rready", mem_m2s.rready, 1'b1);
        tick();
        idle_inputs();
        #1;
        check_b("lastflush_busy", arb_busy, 1'b0);
        request(1'b1, 1'b0, 1'b0, 32'h8000_3100, 32'h0, 8'd0);
        tick();
        idle_inputs();
        #1;
        do_burst(1'b1, 1, 1'b1);

        // Async reset mid-RD: outputs clear without a clock edge.
        request(1'b1, 1'b0, 1'b0, 32'h8000_4000, 32'h0, 8'd3);
        tick();
        idle_inputs();
        mem_s2m.arready = 1'b1;
        tick();
        mem_s2m.arready = 1'b0;
        mem_s2m.rvalid  = 1'b1;
        ifu_m2s.rready  = 1'b1;
        #1;
        check_b("midrd_fwd", ifu_s2m.rvalid, 1'b1);
        #2;
        ifu_m2s.arvalid = 1'b1;
        lsu_m2s.arvalid = 1'b1;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrd_reset");
        mem_s2m.rvalid  = 1'b0;
        ifu_m2s.rready  = 1'b0;
        lsu_m2s.arvalid = 1'b0;
        ifu_m2s.araddr  = 32'h8000_5000;
        #2;
        reset = 1'b1;
        #1;
        check_b("post_reset_ifu_arready", ifu_s2m.arready, 1'b1);
        tick();
        idle_inputs();
        #1;
        check_w("post_reset_araddr", 64'(mem_m2s.araddr), 64'h8000_5000);
        do_burst(1'b1, 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
